// File: rtl/packet_injector.sv
// packet_injector
//   Host-writable ingress buffer for the three switch input ports. Software
//   pushes 32-bit words over an Avalon-MM slave into one of three FIFOs. Each
//   FIFO drains through a registered valid/ready stage into its switch port.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   chipselect, read, write    Avalon slave strobes
//   address[3:0]               Avalon word address
//   writedata[31:0]            Avalon write data
//   readdata[31:0]             registered Avalon read data (251 when idle)
//   dataN[31:0], validN        head word and valid for switch port N
//   readyN                     switch port N accepts dataN
module packet_injector #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [31:0] data1,
  output logic [31:0] data2,
  output logic [31:0] data3,
  output logic        valid1,
  output logic        valid2,
  output logic        valid3,
  input  logic        ready1,
  input  logic        ready2,
  input  logic        ready3
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   mem_q [3][DEPTH];
  logic [AW-1:0] wr_ptr_q [3], wr_ptr_d [3];
  logic [AW-1:0] rd_ptr_q [3], rd_ptr_d [3];
  logic [CW-1:0] occ_q [3], occ_d [3];
  logic [11:0]   sent_q [3], sent_d [3];
  logic [31:0]   data_q [3], data_d [3];
  logic [2:0]    valid_q, valid_d;
  logic [2:0]    en_q, en_d;
  logic [2:0]    ovf_q, ovf_d;
  logic [31:0]   readdata_q, readdata_d;

  logic       wr_en, rd_en;
  logic [2:0] ready, push, full, push_ok, load, xfer;

  assign ready = {ready3, ready2, ready1};

  always_comb begin
    wr_en   = chipselect && write;
    rd_en   = chipselect && read;
    en_d    = en_q;
    ovf_d   = ovf_q;
    push    = '0;
    full    = '0;
    push_ok = '0;
    load    = '0;
    xfer    = '0;
    valid_d = valid_q;
    for (int n = 0; n < 3; n++) begin
      wr_ptr_d[n] = wr_ptr_q[n];
      rd_ptr_d[n] = rd_ptr_q[n];
      occ_d[n]    = occ_q[n];
      sent_d[n]   = sent_q[n];
      data_d[n]   = data_q[n];
    end

    // Overflow clear happens first so a same-cycle set (impossible today,
    // since both need distinct addresses) would still win.
    if (wr_en && address == 4'd14) ovf_d = ovf_q & ~writedata[2:0];
    if (wr_en && address == 4'd0)  en_d  = writedata[2:0];

    for (int n = 0; n < 3; n++) begin
      push[n]    = wr_en && (address == 4'(n + 1));
      // Full is judged before any same-edge pop, so a push to a full FIFO
      // is dropped even while the output stage drains it.
      full[n]    = (occ_q[n] == CW'(DEPTH));
      push_ok[n] = push[n] && !full[n];
      // Output stage may take a new word when empty or being emptied now.
      load[n]    = (!valid_q[n] || ready[n]) && en_q[n] && (occ_q[n] != '0);
      xfer[n]    = valid_q[n] && ready[n];

      wr_ptr_d[n] = wr_ptr_q[n] + AW'(push_ok[n]);
      rd_ptr_d[n] = rd_ptr_q[n] + AW'(load[n]);
      occ_d[n]    = occ_q[n] + CW'(push_ok[n]) - CW'(load[n]);
      sent_d[n]   = sent_q[n] + 12'(xfer[n]);
      valid_d[n]  = load[n] | (valid_q[n] & ~xfer[n]);
      data_d[n]   = load[n] ? mem_q[n][rd_ptr_q[n]] : data_q[n];
      if (push[n] && full[n]) ovf_d[n] = 1'b1;
    end

    readdata_d = 32'd251;
    if (rd_en) begin
      case (address)
        4'd0:    readdata_d = {29'b0, en_q};
        4'd8:    readdata_d = 32'(occ_q[0]);
        4'd9:    readdata_d = 32'(occ_q[1]);
        4'd10:   readdata_d = 32'(occ_q[2]);
        4'd11:   readdata_d = {20'b0, sent_q[0]};
        4'd12:   readdata_d = {20'b0, sent_q[1]};
        4'd13:   readdata_d = {20'b0, sent_q[2]};
        4'd14:   readdata_d = {29'b0, ovf_q};
        default: readdata_d = 32'd252;
      endcase
    end
  end

  // FIFO storage carries no reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 3; n++) begin
      if (push_ok[n]) mem_q[n][wr_ptr_q[n]] <= writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q       <= '0;
      ovf_q      <= '0;
      valid_q    <= '0;
      readdata_q <= 32'd251;
      for (int n = 0; n < 3; n++) begin
        wr_ptr_q[n] <= '0;
        rd_ptr_q[n] <= '0;
        occ_q[n]    <= '0;
        sent_q[n]   <= '0;
        data_q[n]   <= '0;
      end
    end else begin
      en_q       <= en_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
      readdata_q <= readdata_d;
      for (int n = 0; n < 3; n++) begin
        wr_ptr_q[n] <= wr_ptr_d[n];
        rd_ptr_q[n] <= rd_ptr_d[n];
        occ_q[n]    <= occ_d[n];
        sent_q[n]   <= sent_d[n];
        data_q[n]   <= data_d[n];
      end
    end
  end

  assign readdata = readdata_q;
  assign data1    = data_q[0];
  assign data2    = data_q[1];
  assign data3    = data_q[2];
  assign valid1   = valid_q[0];
  assign valid2   = valid_q[1];
  assign valid3   = valid_q[2];

endmodule

// File: doc/packet_injector.md
# packet_injector

Host-writable ingress buffer feeding the three switch input ports. Software writes 32-bit packet words over the Avalon-MM slave into one of three per-port FIFOs. Each FIFO drains through a registered valid/ready output stage into its switch port, giving the write-side counterpart of the result capture buffer. Status registers expose FIFO occupancy, words sent and overflow flags to software.

## Interface
- DEPTH, 16: entries per port FIFO; power of two, at least 2. Occupancy width is CW = log2(DEPTH)+1.
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- chipselect  in  1  Avalon slave select.
- read  in  1  Avalon read strobe.
- write  in  1  Avalon write strobe.
- address  in  4  Avalon word address.
- writedata  in  32  Avalon write data.
- readdata  out  32  registered Avalon read data.
- data1, data2, data3  out  32  head word presented to switch port n.
- valid1, valid2, valid3  out  1  data n is valid.
- ready1, ready2, ready3  in  1  switch port n accepts data n.

## Operation
- Writes (chipselect && write):
  - Address 0: control. Bits [2:0] are port drain enables en[n]. Reset value 0.
  - Address 1/2/3: push writedata into FIFO 1/2/3. If that FIFO is full, drop the word and set overflow[n].
  - Address 14: clear overflow[n] for each bit n of writedata[2:0] that is 1.
  - Any other address: ignore.
- Reads (chipselect && read), readdata registered next edge, no side effects:
  - Address 0: {29'b0, en}.
  - Address 8/9/10: occupancy of FIFO 1/2/3, zero-extended. Excludes any word held in the output stage.
  - Address 11/12/13: sent count 1/2/3, 12-bit, zero-extended.
  - Address 14: {29'b0, overflow[2:0]}.
  - Any other address: 252.
  - No read this cycle: readdata <= 251.
- Output stage per port, evaluated each edge:
  - Transfer occurs when valid && ready.
  - Load: if (!valid || ready) && en && FIFO non-empty, then data <= FIFO head, valid <= 1, pop.
  - Otherwise, on a transfer, valid <= 0.
  - data is held stable while valid && !ready.
- Once valid is asserted, it is never withdrawn before a transfer. Clearing en[n] only stops new loads; the held word stays valid until accepted.
- Sent count n increments on each transfer and wraps 4095 -> 0.
- Push and pop to the same FIFO on the same edge: both take effect and occupancy is unchanged. A push to a full FIFO while it pops on the same edge is still dropped (full is evaluated before the pop).
- FIFO pointers are log2(DEPTH) bits and wrap naturally. Full when occupancy == DEPTH; empty when occupancy == 0.

## Timing
- Reset values:
  - valid1..3 = 0, data1..3 = 0, readdata = 251.
  - en = 0, overflow = 0.
  - Occupancies, pointers and sent counts = 0.
- Reset mid-transfer discards all FIFO contents and the held output words.
- Read latency: address sampled in cycle k, readdata valid in cycle k+1.
- Write-to-status latency: a push in cycle k is visible in occupancy read data at cycle k+2 (read issued in k+1).
- Push-to-port latency: a word pushed in cycle k into an empty FIFO with en set and the output stage free gives valid in cycle k+2.
- Throughput: one word per cycle per port with ready held high and the FIFO non-empty. No bubble between consecutive words.
- All three ports operate independently and concurrently. The Avalon slave handles at most one access per cycle; a cycle with both read and write performs both.

## Test plan
- **Basic drain:** reset; push 0xA1, 0xA2, 0xA3 to address 1; write 0x1 to address 0; hold ready1=1 -> valid1 high for 3 consecutive cycles with data1 = 0xA1, 0xA2, 0xA3; read address 11 returns 3; read address 8 returns 0.
- **Backpressure:** en=0x2; push 0xB0, 0xB1 to address 2; ready2=0 for 5 cycles -> data2 holds 0xB0 with valid2=1 and occupancy reads 1; then ready2=1 -> 0xB1 follows on the next cycle, then valid2=0.
- **Overflow:** en=0; push DEPTH+2 words to address 3 -> address 10 reads DEPTH and address 14 reads 0x4; write 0x4 to address 14 -> reads 0; enable port 3 -> exactly DEPTH words emerge, in order.
- **Simultaneous push/pop on full FIFO:** FIFO 1 full, ready1=1, push on the same edge as a pop -> word dropped, overflow[0]=1, occupancy DEPTH-1.
- **Disable mid-stream:** port 1 streaming with ready1=0; clear en -> the held word stays valid; after one ready1 pulse, valid1=0 and remaining words stay queued with occupancy unchanged.
- **Reset and sentinels:** assert reset while valid and FIFOs are loaded -> all outputs at reset values on the next cycle; read address 5 returns 252; idle cycle readdata = 251; sent count wrap 4095 -> 0 after 4096 transfers.
